// File: rtl/serial_frame_rx.sv
// Parametrised serial frame receiver: start, data, optional parity, stop bits.
// Optional SERIAL_RX_ERR_CNT_EN adds a saturating err_count output.
module serial_frame_rx #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int MSB_FIRST   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err
`ifdef SERIAL_RX_ERR_CNT_EN
  ,
  output logic [15:0]          err_count
`endif
);

  if (DATA_BITS < 5 || DATA_BITS > 16) begin : g_bad_data
    $error("serial_frame_rx: DATA_BITS must be 5..16");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
    $error("serial_frame_rx: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("serial_frame_rx: STOP_BITS must be 1 or 2");
  end

  localparam logic       HAS_PAR   = (PARITY_MODE != 0);
  localparam logic       ODD_PAR   = (PARITY_MODE == 2);
  localparam logic [4:0] LAST_DATA = 5'(DATA_BITS - 1);
  localparam logic [4:0] LAST_STOP = 5'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_ERR
  } state_t;

  state_t               r_state;
  logic [4:0]           r_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_xor;
  logic                 r_pbad;
  logic                 r_done;
  logic                 r_perr;
  logic                 r_ferr;
  logic [DATA_BITS-1:0] w_shift_nxt;

  if (MSB_FIRST != 0) begin : g_msb
    assign w_shift_nxt = {r_shift[DATA_BITS-2:0], in};
  end else begin : g_lsb
    assign w_shift_nxt = {in, r_shift[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_xor   <= 1'b0;
      r_pbad  <= 1'b0;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // DONE doubles as IDLE so back-to-back frames need no gap
          if (!in) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_xor   <= 1'b0;
            r_pbad  <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          r_shift <= w_shift_nxt;
          r_xor   <= r_xor ^ in;
          if (r_cnt == LAST_DATA) begin
            r_cnt   <= '0;
            r_state <= HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_PARITY: begin
          r_pbad  <= ((r_xor ^ in) != ODD_PAR);
          r_state <= S_STOP;
        end
        S_STOP: begin
          if (!in) begin
            r_state <= S_ERR;
            r_ferr  <= 1'b1;
          end else if (r_cnt == LAST_STOP) begin
            r_state <= S_DONE;
            r_data  <= r_shift;
            if (HAS_PAR && r_pbad) r_perr <= 1'b1;
            else                   r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_ERR: begin
          if (in) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data   = r_data;
  assign done       = r_done;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;

`ifdef SERIAL_RX_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if ((r_perr || r_ferr) && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: 8N1, 7E2 MSB-first and 8N2 instances.
// Checks frames, back-to-back timing, parity/framing errors and reset.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in0 = 1'b1;
  logic       in1 = 1'b1;
  logic       in2 = 1'b1;
  logic [7:0] od0;
  logic [6:0] od1;
  logic [7:0] od2;
  logic       dn0, pe0, fe0;
  logic       dn1, pe1, fe1;
  logic       dn2, pe2, fe2;
`ifdef SERIAL_RX_ERR_CNT_EN
  logic [15:0] ec0, ec1, ec2;
  int          exp_ec0 = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int          dtime[$];
  logic [7:0]  ddata[$];

  always #5 clk = ~clk;

  serial_frame_rx u0 (
    .clk(clk), .reset(reset), .in(in0), .out_data(od0),
    .done(dn0), .parity_err(pe0), .frame_err(fe0)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .err_count(ec0)
`endif
  );

  serial_frame_rx #(
    .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .MSB_FIRST(1)
  ) u1 (
    .clk(clk), .reset(reset), .in(in1), .out_data(od1),
    .done(dn1), .parity_err(pe1), .frame_err(fe1)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .err_count(ec1)
`endif
  );

  serial_frame_rx #(.STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .in(in2), .out_data(od2),
    .done(dn2), .parity_err(pe2), .frame_err(fe2)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .err_count(ec2)
`endif
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dn0) begin
      dtime.push_back(cyc);
      ddata.push_back(od0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic b0(input logic b);
    @(negedge clk);
    in0 = b;
  endtask

  task automatic b1(input logic b);
    @(negedge clk);
    in1 = b;
  endtask

  task automatic b2(input logic b);
    @(negedge clk);
    in2 = b;
  endtask

  task automatic send0(input logic [7:0] d, input logic s);
    b0(1'b0);
    for (int i = 0; i < 8; i++) b0(d[i]);
    b0(s);
  endtask

  task automatic send1(input logic [6:0] d, input logic p,
                       input logic s1, input logic s2);
    b1(1'b0);
    for (int i = 6; i >= 0; i--) b1(d[i]);
    b1(p);
    b1(s1);
    b1(s2);
  endtask

  task automatic send2(input logic [7:0] d, input logic s1,
                       input logic s2);
    b2(1'b0);
    for (int i = 0; i < 8; i++) b2(d[i]);
    b2(s1);
    b2(s2);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       done;
    logic       ferr;
    logic [7:0] od;
  } vec_t;

  vec_t        tv[6];
  logic [11:0] st;

  initial begin
    tv[0] = '{8'h12, 1'b0, 1'b0, 1'b1, 8'hA5};
    tv[1] = '{8'h34, 1'b1, 1'b1, 1'b0, 8'h34};
    tv[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
    tv[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'hFF};
    tv[4] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3};
    tv[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
    st = 12'b110101001011;

    repeat (2) @(negedge clk);
    chk("rst done0", 32'(dn0), 0);
    chk("rst ferr0", 32'(fe0), 0);
    chk("rst data0", 32'(od0), 0);
    chk("rst data1", 32'(od1), 0);
`ifdef SERIAL_RX_ERR_CNT_EN
    chk("rst ecnt0", 32'(ec0), 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 12; i++) b0(st[11-i]);
    @(negedge clk);
    chk("a5 done", 32'(dn0), 1);
    chk("a5 data", 32'(od0), 32'h A5);
    chk("a5 perr", 32'(pe0), 0);
    chk("a5 ferr", 32'(fe0), 0);
    @(negedge clk);
    chk("a5 done pulse", 32'(dn0), 0);

    for (int i = 0; i < 6; i++) begin
      send0(tv[i].d, tv[i].stop);
      @(negedge clk);
      chk($sformatf("v%0d done", i), 32'(dn0), 32'(tv[i].done));
      chk($sformatf("v%0d ferr", i), 32'(fe0), 32'(tv[i].ferr));
      chk($sformatf("v%0d perr", i), 32'(pe0), 0);
      chk($sformatf("v%0d data", i), 32'(od0), 32'(tv[i].od));
      @(negedge clk);
      chk($sformatf("v%0d pulse", i), 32'({dn0, fe0}), 0);
      repeat (4) @(negedge clk);
      in0 = 1'b1;
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d hold", i), 32'(od0), 32'(tv[i].od));
`ifdef SERIAL_RX_ERR_CNT_EN
      if (tv[i].ferr) exp_ec0++;
      chk($sformatf("v%0d ecnt", i), 32'(ec0), 32'(exp_ec0));
`endif
    end

    dtime.delete();
    ddata.delete();
    send0(8'h3C, 1'b1);
    send0(8'h81, 1'b1);
    repeat (3) @(negedge clk);
    chk("b2b count", 32'(dtime.size()), 2);
    if (dtime.size() == 2) begin
      chk("b2b gap", 32'(dtime[1] - dtime[0]), 10);
      chk("b2b d0", 32'(ddata[0]), 32'h3C);
      chk("b2b d1", 32'(ddata[1]), 32'h81);
    end

    send1(7'h55, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("p55 done", 32'(dn1), 1);
    chk("p55 perr", 32'(pe1), 0);
    chk("p55 data", 32'(od1), 32'h55);
    send1(7'h55, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("p55b done", 32'(dn1), 0);
    chk("p55b perr", 32'(pe1), 1);
    chk("p55b data", 32'(od1), 32'h55);
    @(negedge clk);
    chk("p55b pulse", 32'(pe1), 0);
    send1(7'h0F, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("p0f perr", 32'(pe1), 1);
    chk("p0f data", 32'(od1), 32'h0F);
    send1(7'h01, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("p01 done", 32'(dn1), 1);
    chk("p01 data", 32'(od1), 32'h01);
    send1(7'h2A, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("p2a ferr", 32'(fe1), 1);
    chk("p2a done", 32'({dn1, pe1}), 0);
    chk("p2a data", 32'(od1), 32'h01);
    in1 = 1'b1;
    repeat (2) @(negedge clk);
`ifdef SERIAL_RX_ERR_CNT_EN
    chk("p ecnt", 32'(ec1), 3);
`endif

    send2(8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    chk("s5a done", 32'(dn2), 1);
    chk("s5a data", 32'(od2), 32'h5A);
    send2(8'h77, 1'b1, 1'b0);
    @(negedge clk);
    chk("s77 ferr", 32'(fe2), 1);
    chk("s77 done", 32'(dn2), 0);
    chk("s77 data", 32'(od2), 32'h5A);
    @(negedge clk);
    chk("s77 pulse", 32'(fe2), 0);
    in2 = 1'b1;
    repeat (2) @(negedge clk);

    b0(1'b0);
    for (int i = 0; i < 4; i++) b0(1'b1);
    @(negedge clk);
    reset = 1'b1;
    in0 = 1'b1;
    @(negedge clk);
    chk("mrst data0", 32'(od0), 0);
    chk("mrst outs0", 32'({dn0, pe0, fe0}), 0);
    chk("mrst data2", 32'(od2), 0);
`ifdef SERIAL_RX_ERR_CNT_EN
    chk("mrst ecnt0", 32'(ec0), 0);
`endif
    reset = 1'b0;
    @(negedge clk);
    send0(8'h5A, 1'b1);
    @(negedge clk);
    chk("r5a done", 32'(dn0), 1);
    chk("r5a data", 32'(od0), 32'h5A);
`ifdef SERIAL_RX_ERR_CNT_EN
    send0(8'h12, 1'b0);
    @(negedge clk);
    in0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("r ecnt0", 32'(ec0), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
